// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC sequencing controller
package mac_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;
   localparam int OP_W        = 8;
   localparam int PROD_W      = 15;
   localparam int MUL_LAT_DEF = 8;
   localparam int CORNER      = 16384;
endpackage

// File: rtl/mac_vld_pipe.sv
// mac_vld_pipe: valid/corner shift register tracking products in flight through the multiplier
module mac_vld_pipe import mac_pkg::*; #(
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic in_vld,
   input  logic in_cor,
   output logic tail_vld,
   output logic tail_cor,
   output logic rest
);
   localparam logic [MUL_LAT-1:0] NOT_TAIL = {MUL_LAT{1'b1}} >> 1;
   logic [MUL_LAT-1:0] vld_q;
   logic [MUL_LAT-1:0] cor_q;
   // shift one issue marker per cycle; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         cor_q <= '0;
      end else begin
         vld_q <= MUL_LAT'({vld_q, in_vld});
         cor_q <= MUL_LAT'({cor_q, in_vld & in_cor});
      end
   end
   assign tail_vld = vld_q[MUL_LAT-1];
   assign tail_cor = cor_q[MUL_LAT-1];
   assign rest     = |(vld_q & NOT_TAIL);
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: dot-product sequencer around an external pipelined multiplier; MAC_SAT_EN enables saturation
module mac_seq_ctrl import mac_pkg::*; #(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int ACC_W   = 24,
   parameter int LEN_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         cfg_len,
   output logic                     busy,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [OP_W-1:0]   in_x,
   input  logic signed [OP_W-1:0]   in_y,
   output logic [OP_W-1:0]          mul_x,
   output logic [OP_W-1:0]          mul_y,
   input  logic signed [PROD_W-1:0] mul_p,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_acc,
   output logic                     out_sat
);
   localparam logic [1:0] IDLE  = 2'(ST_IDLE);
   localparam logic [1:0] ISSUE = 2'(ST_ISSUE);
   localparam logic [1:0] DRAIN = 2'(ST_DRAIN);
   localparam logic [1:0] DONE  = 2'(ST_DONE);
   logic [1:0]              state, state_nx;
   logic [LEN_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc_q, acc_nx, term;
   logic                    hs, go, tail_vld, tail_cor, rest;
   assign go        = state == IDLE && start;
   assign hs        = state == ISSUE && in_valid;
   assign busy      = state != IDLE;
   assign in_ready  = state == ISSUE;
   assign out_valid = state == DONE;
   assign out_acc   = acc_q;
   assign mul_x     = hs ? in_x : '0;
   assign mul_y     = hs ? in_y : '0;
   // -128*-128 overflows the 15-bit product, so its tail substitutes the true value
   assign term      = tail_cor ? ACC_W'(CORNER) : {{(ACC_W-PROD_W){mul_p[PROD_W-1]}}, mul_p};

   mac_vld_pipe #(.MUL_LAT(MUL_LAT)) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (hs),
      .in_cor   (in_x == 8'h80 && in_y == 8'h80),
      .tail_vld (tail_vld),
      .tail_cor (tail_cor),
      .rest     (rest)
   );

`ifdef MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic signed [ACC_W:0] sum;
   logic                  ovf, sat_q;
   assign sum     = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
   assign ovf     = sum[ACC_W] != sum[ACC_W-1];
   assign acc_nx  = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
   assign out_sat = sat_q;
   // sticky per-job saturation flag
   always_ff @(posedge clk)
      sat_q <= (rst || go) ? 1'b0 : (tail_vld && ovf) ? 1'b1 : sat_q;
`else
   assign acc_nx  = acc_q + term;
   assign out_sat = 1'b0;
`endif

   // next-state selection for IDLE -> ISSUE -> DRAIN -> DONE -> IDLE
   always_comb
      state_nx = (state == IDLE)  ? (start ? ((cfg_len == '0) ? DONE : ISSUE) : IDLE) :
                 (state == ISSUE) ? ((hs && cnt == LEN_W'(1)) ? DRAIN : ISSUE) :
                 (state == DRAIN) ? ((tail_vld && !rest) ? DONE : DRAIN) :
                                    (out_ready ? IDLE : DONE);

   // state, remaining count and accumulator registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         acc_q <= '0;
      end else begin
         state <= state_nx;
         cnt   <= go ? cfg_len : hs ? cnt - 1'b1 : cnt;
         acc_q <= go ? '0 : tail_vld ? acc_nx : acc_q;
      end
   end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed self-checking bench for mac_seq_ctrl with a behavioural multiplier
module tb_mac_seq_ctrl;
   localparam int LAT = 8;
   localparam int AW  = 16;
   logic                  clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
   logic [7:0]            cfg_len = 0;
   logic signed [7:0]     in_x = 0, in_y = 0;
   logic [7:0]            mul_x, mul_y;
   logic signed [14:0]    mul_p;
   logic                  busy, in_ready, out_valid, out_sat;
   logic signed [AW-1:0]  out_acc;
   logic signed [15:0]    prod;
   logic [14:0]           mp [LAT];
   int                    checks = 0, fails = 0, cyc = 0, hs_cyc = 0, dn_cyc = 0;
   logic signed [AW-1:0]  held;

   mac_seq_ctrl #(.MUL_LAT(LAT), .ACC_W(AW), .LEN_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign prod  = $signed(mul_x) * $signed(mul_y);
   assign mul_p = mp[LAT-1];
   always @(posedge clk) begin
      mp[0] <= prod[14:0];
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic start_job(input logic [7:0] len);
      @(negedge clk);
      start = 1;
      cfg_len = len;
      @(negedge clk);
      start = 0;
   endtask

   task automatic send(input logic signed [7:0] x, input logic signed [7:0] y);
      in_valid = 1;
      in_x = x;
      in_y = y;
      #1;
      check("in_ready_hs", in_ready, 1);
      check("mul_x_hs", $signed(mul_x), x);
      check("mul_y_hs", $signed(mul_y), y);
      hs_cyc = cyc;
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         check("in_ready_gap", in_ready, 1);
         check("mul_x_gap", mul_x, 0);
         @(negedge clk);
      end
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!out_valid && k < 60) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done"}, out_valid, 1);
      dn_cyc = cyc;
   endtask

   task automatic accept();
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      check("busy_after_accept", busy, 0);
      check("out_valid_after_accept", out_valid, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_acc", out_acc, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_mul_x", mul_x, 0);
      check("rst_mul_y", mul_y, 0);
      rst = 0;

      start_job(3);
      check("issue_busy", busy, 1);
      send(1, 1);
      send(2, 2);
      send(8, 3);
      check("drain_in_ready", in_ready, 0);
      wait_done("b2b");
      check("b2b_acc", out_acc, 29);
      check("b2b_latency", dn_cyc - hs_cyc, LAT + 1);
      accept();

      start_job(1);
      send(-128, -128);
      wait_done("corner");
      check("corner_acc", out_acc, 16384);
      check("corner_sat", out_sat, 0);
      accept();

      start_job(2);
      send(-86, 85);
      gap(2);
      send(85, -86);
      wait_done("gap");
      check("gap_acc", out_acc, -14620);
      accept();

      start_job(3);
      send(127, 127);
      send(127, 127);
      send(127, 127);
      wait_done("ovf");
`ifdef MAC_SAT_EN
      check("ovf_acc", out_acc, 32767);
      check("ovf_sat", out_sat, 1);
`else
      check("ovf_acc", out_acc, -17149);
      check("ovf_sat", out_sat, 0);
`endif
      held = out_acc;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         cfg_len = 0;
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_acc", out_acc, held);
      end
      start = 0;
      accept();
      #1;
      check("start_ignored_busy", busy, 0);

      start_job(3);
      send(50, 50);
      send(60, 60);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_acc", out_acc, 0);
      start_job(0);
      wait_done("zero");
      repeat (LAT + 2) @(negedge clk);
      check("zero_acc", out_acc, 0);
      check("zero_sat", out_sat, 0);
      accept();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
